// File: rtl/branch_sentinel_bank_pkg.sv
// Shared definitions for branch_sentinel_bank: sweep FSM states and the
// layout of the configuration address ({entry index, sel}).
package branch_sentinel_bank_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } sweep_state_t;

    // sel bit of the configuration address
    localparam logic SEL_SENTINEL = 1'b0;
    localparam logic SEL_MASK     = 1'b1;

    // Configuration-address fields: sel in the LSB, entry index above it
    localparam int CFG_SEL_WIDTH = 1;
    localparam int CFG_SEL_LSB   = 0;
    localparam int CFG_INDEX_LSB = CFG_SEL_LSB + CFG_SEL_WIDTH;

endpackage

// File: rtl/Delay_Line.sv
// Fixed-depth register delay line, cleared synchronously.
module Delay_Line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [DEPTH-1:0][WIDTH-1:0] vld_pipe;

    // Shift the input through DEPTH registers
    always_ff @(posedge clock) begin
        if (clear) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in;
            for (int i = 1; i < DEPTH; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign out = vld_pipe[DEPTH-1];

endmodule

// File: rtl/RAM_SDP.sv
// Simple dual-port RAM: one write port, one registered read port.
// READ_NEW_DATA selects forwarding of same-address write data on a read.
module RAM_SDP #(
    parameter int WORD_WIDTH    = 36,
    parameter int ADDR_WIDTH    = 3,
    parameter int DEPTH         = 8,
    parameter     RAMSTYLE      = "",
    parameter int READ_NEW_DATA = 0
) (
    input  logic                  clock,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [WORD_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [WORD_WIDTH-1:0] read_data
);

    (* ramstyle = RAMSTYLE *)
    logic [WORD_WIDTH-1:0] mem [DEPTH];

    // Write port plus registered read with selectable read-during-write
    always_ff @(posedge clock) begin
        if (wren)
            mem[write_addr] <= write_data;
        if ((READ_NEW_DATA != 0) && wren && (write_addr == read_addr))
            read_data <= write_data;
        else
            read_data <= mem[read_addr];
    end

endmodule

// File: rtl/Thread_Number.sv
// Round-robin thread counter: 0..THREAD_COUNT-1, wraps, clear forces 0.
module Thread_Number #(
    parameter int THREAD_COUNT       = 8,
    parameter int THREAD_COUNT_WIDTH = 3
) (
    input  logic                          clock,
    input  logic                          clear,
    output logic [THREAD_COUNT_WIDTH-1:0] current_thread
);

    // Advance one thread per cycle, wrapping after the last one
    always_ff @(posedge clock) begin
        if (clear)
            current_thread <= '0;
        else if (current_thread == THREAD_COUNT_WIDTH'(THREAD_COUNT - 1))
            current_thread <= '0;
        else
            current_thread <= current_thread + 1'b1;
    end

endmodule

// File: rtl/branch_sentinel_bank_entry.sv
// sentinel_entry: one sentinel/mask pair per thread. RAM read at stage 0,
// sentinel & ~mask registered with the mask at stage 1, compare against R
// at stage 2 (combinational).
module sentinel_entry
    import branch_sentinel_bank_pkg::*;
#(
    parameter int WORD_WIDTH           = 36,
    parameter int THREAD_COUNT         = 8,
    parameter int THREAD_COUNT_WIDTH   = 3,
    parameter int SENTINEL_INDEX_WIDTH = 2,
    parameter int ENTRY_INDEX          = 0,
    parameter     RAMSTYLE             = "",
    parameter int READ_NEW_DATA        = 0
) (
    input  logic                            clock,
    input  logic                            sweep_wren,
    input  logic [THREAD_COUNT_WIDTH-1:0]   sweep_addr,
    input  logic [THREAD_COUNT_WIDTH-1:0]   thread,
    input  logic                            cfg_wren,
    input  logic                            cfg_sel,
    input  logic [SENTINEL_INDEX_WIDTH-1:0] cfg_index,
    input  logic [WORD_WIDTH-1:0]           cfg_data,
    input  logic [WORD_WIDTH-1:0]           R,
    output logic                            match
);

    logic                          entry_hit;
    logic                          sentinel_wren;
    logic                          mask_wren;
    logic [THREAD_COUNT_WIDTH-1:0] write_addr;
    logic [WORD_WIDTH-1:0]         write_data;
    logic [WORD_WIDTH-1:0]         sentinel_rd;
    logic [WORD_WIDTH-1:0]         mask_rd;
    logic [WORD_WIDTH-1:0]         sentinel_masked_q;
    logic [WORD_WIDTH-1:0]         mask_q;

    // The sweep owns both write ports while it runs
    assign entry_hit     = cfg_wren && (cfg_index == SENTINEL_INDEX_WIDTH'(ENTRY_INDEX));
    assign sentinel_wren = sweep_wren || (entry_hit && (cfg_sel == SEL_SENTINEL));
    assign mask_wren     = sweep_wren || (entry_hit && (cfg_sel == SEL_MASK));
    assign write_addr    = sweep_wren ? sweep_addr : thread;
    assign write_data    = sweep_wren ? '0 : cfg_data;

    RAM_SDP #(
        .WORD_WIDTH    (WORD_WIDTH),
        .ADDR_WIDTH    (THREAD_COUNT_WIDTH),
        .DEPTH         (THREAD_COUNT),
        .RAMSTYLE      (RAMSTYLE),
        .READ_NEW_DATA (READ_NEW_DATA)
    ) u_sentinel_ram (
        .clock      (clock),
        .wren       (sentinel_wren),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr  (thread),
        .read_data  (sentinel_rd)
    );

    RAM_SDP #(
        .WORD_WIDTH    (WORD_WIDTH),
        .ADDR_WIDTH    (THREAD_COUNT_WIDTH),
        .DEPTH         (THREAD_COUNT),
        .RAMSTYLE      (RAMSTYLE),
        .READ_NEW_DATA (READ_NEW_DATA)
    ) u_mask_ram (
        .clock      (clock),
        .wren       (mask_wren),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_addr  (thread),
        .read_data  (mask_rd)
    );

    // Stage 1: pre-mask the sentinel so stage 2 only masks R
    always_ff @(posedge clock) begin
        sentinel_masked_q <= sentinel_rd & ~mask_rd;
        mask_q            <= mask_rd;
    end

    assign match = ((R & ~mask_q) == sentinel_masked_q);

endmodule

// File: rtl/branch_sentinel_bank.sv
// branch_sentinel_bank: per-thread bank of masked sentinels compared against
// the stage-2 result R. A sweep FSM zeroes all storage after clear; outputs
// stay gated until post-sweep data has reached stage 2.
// Optional feature macro: BRANCH_SENTINEL_BANK_HIT_COUNT_EN adds a
// per-thread saturating hit counter shown on hit_count.
module branch_sentinel_bank
    import branch_sentinel_bank_pkg::*;
#(
    parameter int WORD_WIDTH           = 36,
    parameter int SENTINEL_COUNT       = 4,
    parameter int SENTINEL_INDEX_WIDTH = 2,
    parameter int THREAD_COUNT         = 8,
    parameter int THREAD_COUNT_WIDTH   = 3,
    parameter     RAMSTYLE             = "",
    parameter int READ_NEW_DATA        = 0,
    parameter int HIT_COUNT_WIDTH      = 8
) (
    input  logic                            clock,
    input  logic                            clear,
    input  logic [WORD_WIDTH-1:0]           R,
    input  logic                            configuration_wren,
    input  logic [SENTINEL_INDEX_WIDTH:0]   configuration_addr,
    input  logic [WORD_WIDTH-1:0]           configuration_data,
    output logic                            ready,
    output logic [SENTINEL_COUNT-1:0]       match,
    output logic                            any_match,
    output logic [HIT_COUNT_WIDTH-1:0]      hit_count
);

    sweep_state_t                    state;
    logic [THREAD_COUNT_WIDTH-1:0]   thread;
    logic [THREAD_COUNT_WIDTH-1:0]   sweep_addr;
    logic                            sweep_wren;
    logic [SENTINEL_INDEX_WIDTH-1:0] cfg_index;
    logic                            cfg_sel;
    logic                            cfg_in_range;
    logic                            cfg_wren;
    logic                            ready_d2;
    logic                            out_gate;
    logic [SENTINEL_COUNT-1:0]       match_raw;

    Thread_Number #(
        .THREAD_COUNT       (THREAD_COUNT),
        .THREAD_COUNT_WIDTH (THREAD_COUNT_WIDTH)
    ) u_thread (
        .clock          (clock),
        .clear          (clear),
        .current_thread (thread)
    );

    // Sweep FSM: zero one thread address per cycle, then run until clear
    always_ff @(posedge clock) begin
        if (clear) begin
            state      <= SWEEP;
            sweep_addr <= '0;
            ready      <= 1'b0;
        end else begin
            case (state)
                SWEEP: begin
                    if (sweep_addr == THREAD_COUNT_WIDTH'(THREAD_COUNT - 1)) begin
                        state      <= RUN;
                        sweep_addr <= '0;
                        ready      <= 1'b1;
                    end else begin
                        sweep_addr <= sweep_addr + 1'b1;
                    end
                end
                RUN: ready <= 1'b1;
                default: begin
                    state      <= SWEEP;
                    sweep_addr <= '0;
                    ready      <= 1'b0;
                end
            endcase
        end
    end

    assign sweep_wren   = (state == SWEEP);
    assign cfg_index    = configuration_addr[CFG_INDEX_LSB +: SENTINEL_INDEX_WIDTH];
    assign cfg_sel      = configuration_addr[CFG_SEL_LSB];
    assign cfg_in_range = 32'(cfg_index) < 32'(SENTINEL_COUNT);
    assign cfg_wren     = configuration_wren && (state == RUN) && !clear && cfg_in_range;

    genvar g;
    generate
        for (g = 0; g < SENTINEL_COUNT; g++) begin : g_entry
            sentinel_entry #(
                .WORD_WIDTH           (WORD_WIDTH),
                .THREAD_COUNT         (THREAD_COUNT),
                .THREAD_COUNT_WIDTH   (THREAD_COUNT_WIDTH),
                .SENTINEL_INDEX_WIDTH (SENTINEL_INDEX_WIDTH),
                .ENTRY_INDEX          (g),
                .RAMSTYLE             (RAMSTYLE),
                .READ_NEW_DATA        (READ_NEW_DATA)
            ) u_entry (
                .clock      (clock),
                .sweep_wren (sweep_wren),
                .sweep_addr (sweep_addr),
                .thread     (thread),
                .cfg_wren   (cfg_wren),
                .cfg_sel    (cfg_sel),
                .cfg_index  (cfg_index),
                .cfg_data   (configuration_data),
                .R          (R),
                .match      (match_raw[g])
            );
        end
    endgenerate

    // Stage 2 sees post-sweep data two cycles after ready; ready itself drops
    // on the cycle after clear, so the AND closes the gate at once
    Delay_Line #(
        .DEPTH (2),
        .WIDTH (1)
    ) u_ready_delay (
        .clock (clock),
        .clear (clear),
        .in    (ready),
        .out   (ready_d2)
    );

    assign out_gate  = ready && ready_d2;
    assign match     = match_raw & {SENTINEL_COUNT{out_gate}};
    assign any_match = |match;

`ifdef BRANCH_SENTINEL_BANK_HIT_COUNT_EN
    logic [THREAD_COUNT_WIDTH-1:0] thread_s2;
    logic [HIT_COUNT_WIDTH-1:0]    count_s1;
    logic [HIT_COUNT_WIDTH-1:0]    count_s2;
    logic [HIT_COUNT_WIDTH-1:0]    count_next;
    logic                          count_wren;
    logic [THREAD_COUNT_WIDTH-1:0] count_waddr;
    logic [HIT_COUNT_WIDTH-1:0]    count_wdata;

    Delay_Line #(
        .DEPTH (2),
        .WIDTH (THREAD_COUNT_WIDTH)
    ) u_thread_delay (
        .clock (clock),
        .clear (clear),
        .in    (thread),
        .out   (thread_s2)
    );

    RAM_SDP #(
        .WORD_WIDTH    (HIT_COUNT_WIDTH),
        .ADDR_WIDTH    (THREAD_COUNT_WIDTH),
        .DEPTH         (THREAD_COUNT),
        .RAMSTYLE      (RAMSTYLE),
        .READ_NEW_DATA (READ_NEW_DATA)
    ) u_count_ram (
        .clock      (clock),
        .wren       (count_wren),
        .write_addr (count_waddr),
        .write_data (count_wdata),
        .read_addr  (thread),
        .read_data  (count_s1)
    );

    Delay_Line #(
        .DEPTH (1),
        .WIDTH (HIT_COUNT_WIDTH)
    ) u_count_delay (
        .clock (clock),
        .clear (clear),
        .in    (count_s1),
        .out   (count_s2)
    );

    // Saturating increment written back to the stage-2 thread on a hit
    assign count_next  = (count_s2 == {HIT_COUNT_WIDTH{1'b1}}) ? count_s2 : count_s2 + 1'b1;
    assign count_wren  = sweep_wren || any_match;
    assign count_waddr = sweep_wren ? sweep_addr : thread_s2;
    assign count_wdata = sweep_wren ? '0 : count_next;
    assign hit_count   = out_gate ? count_s2 : '0;
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_branch_sentinel_bank.sv
// Scoreboard bench for branch_sentinel_bank (THREAD_COUNT=8, SENTINEL_COUNT=4,
// WORD_WIDTH=36). A cycle-level reference model predicts ready/match/hit_count;
// a negedge monitor pops and compares. The index field is one bit wider than
// clog2(SENTINEL_COUNT) so that out-of-range entries can be addressed.
module tb_branch_sentinel_bank;

    localparam int WW  = 36;
    localparam int SC  = 4;
    localparam int SIW = 3;
    localparam int TC  = 8;
    localparam int TCW = 3;
    localparam int HCW = 2;

    logic            clk = 1'b0;
    logic            clear = 1'b0;
    logic [WW-1:0]   R = '0;
    logic            cfg_wren = 1'b0;
    logic [SIW:0]    cfg_addr = '0;
    logic [WW-1:0]   cfg_data = '0;
    logic            ready;
    logic [SC-1:0]   match;
    logic            any_match;
    logic [HCW-1:0]  hit_count;

    branch_sentinel_bank #(
        .WORD_WIDTH           (WW),
        .SENTINEL_COUNT       (SC),
        .SENTINEL_INDEX_WIDTH (SIW),
        .THREAD_COUNT         (TC),
        .THREAD_COUNT_WIDTH   (TCW),
        .RAMSTYLE             (""),
        .READ_NEW_DATA        (0),
        .HIT_COUNT_WIDTH      (HCW)
    ) dut (
        .clock              (clk),
        .clear              (clear),
        .R                  (R),
        .configuration_wren (cfg_wren),
        .configuration_addr (cfg_addr),
        .configuration_data (cfg_data),
        .ready              (ready),
        .match              (match),
        .any_match          (any_match),
        .hit_count          (hit_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             cyc;
        logic           rdy;
        logic [SC-1:0]  m;
        logic [HCW-1:0] h;
    } exp_t;

    typedef struct {
        int            cyc;
        int            th;
        int            idx;
        logic          sel;
        logic [WW-1:0] d;
    } wr_t;

    exp_t q[$];
    wr_t  pend[$];

    int checks = 0;
    int errors = 0;

    // Reference model: storage as seen by readers, per thread and entry
    logic [WW-1:0] m_sen [TC][SC];
    logic [WW-1:0] m_msk [TC][SC];
    int            m_cnt [TC];
    int            c0 = 0;
    bit            have_c0 = 0;

    function automatic logic [WW-1:0] rand36();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[WW-1:0];
    endfunction

    function automatic int thr_now();
        return (cyc - c0 - 1) % TC;
    endfunction

    task automatic model_zero();
        for (int t = 0; t < TC; t++) begin
            m_cnt[t] = 0;
            for (int e = 0; e < SC; e++) begin
                m_sen[t][e] = '0;
                m_msk[t][e] = '0;
            end
        end
    endtask

    // Drive one cycle of inputs and push the predicted outputs for it
    task automatic step(input logic clr, input logic wr, input logic [SIW:0] addr,
                        input logic [WW-1:0] data, input logic [WW-1:0] r);
        exp_t          e;
        wr_t           w;
        int            k;
        int            s;
        logic [SIW-1:0] ix;
        clear    = clr;
        cfg_wren = wr;
        cfg_addr = addr;
        cfg_data = data;
        R        = r;
        ix       = addr[SIW:1];
        if (have_c0) begin
            while (pend.size() > 0 && pend[0].cyc <= cyc) begin
                w = pend.pop_front();
                if (w.sel) m_msk[w.th][w.idx] = w.d;
                else       m_sen[w.th][w.idx] = w.d;
            end
            k     = cyc - c0;
            e.cyc = cyc;
            e.rdy = (k >= TC + 1);
            e.m   = '0;
            e.h   = '0;
            if (k >= TC + 3) begin
                s = (k - 3) % TC;
                for (int i = 0; i < SC; i++)
                    e.m[i] = ((r & ~m_msk[s][i]) == (m_sen[s][i] & ~m_msk[s][i]));
`ifdef BRANCH_SENTINEL_BANK_HIT_COUNT_EN
                e.h = HCW'(m_cnt[s]);
                if (|e.m && m_cnt[s] < (1 << HCW) - 1) m_cnt[s]++;
`endif
            end
            q.push_back(e);
            if (wr && !clr && k >= TC + 1 && int'(ix) < SC) begin
                w.cyc = cyc + 3;
                w.th  = (k - 1) % TC;
                w.idx = int'(ix);
                w.sel = addr[0];
                w.d   = data;
                pend.push_back(w);
            end
        end
        if (clr) begin
            c0      = cyc;
            have_c0 = 1;
            pend.delete();
            model_zero();
        end
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the requested thread, then issue one write
    task automatic write_cfg(input int th, input int idx, input logic sel, input logic [WW-1:0] d);
        bit             done;
        logic [SIW-1:0] ix;
        done = 0;
        ix   = SIW'(idx);
        for (int n = 0; n < 2 * TC && !done; n++) begin
            if (thr_now() == th) begin
                step(1'b0, 1'b1, {ix, sel}, d, '0);
                done = 1;
            end else begin
                step(1'b0, 1'b0, '0, '0, '0);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL write_cfg_timeout thread=%0d", th);
        end
    endtask

    // R biased towards hitting a live sentinel of the current stage-2 thread
    function automatic logic [WW-1:0] pick_r();
        int s;
        int e;
        s = (cyc - c0 - 3) % TC;
        if (s < 0) s += TC;
        e = $urandom_range(0, SC - 1);
        if ($urandom_range(0, 1) == 1)
            return (m_sen[s][e] & ~m_msk[s][e]) | (rand36() & m_msk[s][e]);
        return rand36();
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v, input int c);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, act, exp_v);
        end
    endtask

    exp_t mon_e;
    // Monitor: compare every predicted cycle against the DUT outputs
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_e = q.pop_front();
            if (mon_e.cyc < cyc) begin
                chk("stale_expectation", 64'(cyc), 64'(mon_e.cyc), cyc);
            end else begin
                chk("ready",     64'(ready),     64'(mon_e.rdy),  cyc);
                chk("match",     64'(match),     64'(mon_e.m),    cyc);
                chk("any_match", 64'(any_match), 64'(|mon_e.m),   cyc);
                chk("hit_count", 64'(hit_count), 64'(mon_e.h),    cyc);
            end
        end
    end

    logic [SIW:0]  ra;
    logic [WW-1:0] rd;

    initial begin
        model_zero();
        repeat (3) @(posedge clk);
        #1;

        // Post-clear: zero storage matches R=0 everywhere, R=1 nowhere
        step(1'b1, 1'b0, '0, '0, '0);
        repeat (26) step(1'b0, 1'b0, '0, '0, '0);
        repeat (8)  step(1'b0, 1'b0, '0, '0, 36'd1);

        // Masked match on thread 3 entry 2
        write_cfg(3, 2, 1'b0, 36'hABC);
        write_cfg(3, 2, 1'b1, 36'h00F);
        repeat (16) step(1'b0, 1'b0, '0, '0, 36'hAB5);

        // Writes during sweep are dropped, then a clear five cycles in
        step(1'b1, 1'b0, '0, '0, '0);
        step(1'b0, 1'b1, {3'd1, 1'b0}, rand36(), '0);
        step(1'b0, 1'b1, {3'd1, 1'b1}, 36'h0_0000_00FF, '0);
        step(1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b0, '0, '0, '0);
        step(1'b1, 1'b0, '0, '0, '0);
        repeat (20) step(1'b0, 1'b0, '0, '0, '0);

        // Out-of-range entry index 5 leaves all storage untouched
        write_cfg(2, 5, 1'b0, 36'h123456789);
        write_cfg(2, 5, 1'b1, {WW{1'b1}});
        repeat (16) step(1'b0, 1'b0, '0, '0, '0);

        // Hit counting: every thread matches R=0 on consecutive passes
        step(1'b1, 1'b0, '0, '0, '0);
        repeat (56) step(1'b0, 1'b0, '0, '0, '0);
        repeat (8)  step(1'b0, 1'b0, '0, '0, 36'd7);

        // Randomised traffic with occasional clears
        for (int n = 0; n < 800; n++) begin
            ra = (SIW + 1)'($urandom_range(0, (1 << (SIW + 1)) - 1));
            rd = ($urandom_range(0, 3) == 0) ? (rand36() & 36'hFF) : rand36();
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), ra, rd, pick_r());
        end

        repeat (4) step(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(q.size()), 64'd0, cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_sentinel_bank.md
# branch_sentinel_bank

Multi-entry, multi-threaded sentinel matcher for branch logic: compares the previous instruction result `R` against `SENTINEL_COUNT` masked sentinel values per thread and reports per-entry and any-entry matches. It succeeds the single-sentinel checker beside the branch detectors. Its storage is self-initialising: a sweep state machine after `clear` zeroes all sentinel and mask RAM contents, so every entry starts as an exact match against zero. An optional per-thread saturating hit counter is available.

## Interface
- `WORD_WIDTH`, 0: data and sentinel width.
- `SENTINEL_COUNT`, 0: sentinel/mask pairs per thread (≥1).
- `SENTINEL_INDEX_WIDTH`, 0: clog2(`SENTINEL_COUNT`), minimum 1.
- `THREAD_COUNT`, 0: number of threads (≥2).
- `THREAD_COUNT_WIDTH`, 0: clog2(`THREAD_COUNT`).
- `RAMSTYLE`, "": RAM inference attribute.
- `READ_NEW_DATA`, 0: RAM read-during-write behaviour.
- `HIT_COUNT_WIDTH`, 8: hit counter width (used only with the feature macro).
- `clock`, in, 1: single clock.
- `clear`, in, 1: synchronous, active-high reset.
- `R`, in, `WORD_WIDTH`: result of the previous instruction, stage-2 aligned.
- `configuration_wren`, in, 1: write strobe for the current thread.
- `configuration_addr`, in, `SENTINEL_INDEX_WIDTH+1`: {entry index, sel}. sel 0 selects the sentinel, sel 1 selects the mask.
- `configuration_data`, in, `WORD_WIDTH`: write data.
- `ready`, out, 1: high once the sweep is complete.
- `match`, out, `SENTINEL_COUNT`: per-entry match at stage 2.
- `any_match`, out, 1: OR of `match`.
- `hit_count`, out, `HIT_COUNT_WIDTH`: hits for the stage-2 thread (feature only).

## Operation
- Thread counter: rotates 0..`THREAD_COUNT`-1 and wraps. `clear` forces it to 0. It keeps rotating during the sweep.
- Storage: one sentinel RAM and one mask RAM per entry, each `THREAD_COUNT` deep.
  - Read address is always the current thread.
  - Write address is the current thread, or the sweep address while sweeping.
- FSM states:
  - SWEEP: entered on `clear`. A sweep address counter runs 0..`THREAD_COUNT`-1, writing zero to every sentinel and mask RAM (all entries in parallel), one thread per cycle. After the last address the FSM goes to RUN.
  - RUN: normal operation. Stays in RUN until `clear`.
  - `clear` in any state, including mid-sweep, restarts SWEEP at address 0.
- Configuration writes:
  - Accepted only in RUN. Ignored in SWEEP.
  - A write with entry index ≥ `SENTINEL_COUNT` is ignored.
  - A write affects only the addressed RAM of the current thread. It is visible on that thread's next pass.
- Match per entry i: `match[i] = ((R & ~mask_i) == (sentinel_i & ~mask_i))`.
  - Mask bit 1 means don't-care. Mask 0 means exact match.
  - An all-ones mask always matches.
- `sentinel & ~mask` is computed at stage 1 and registered together with the mask.

## Timing
- Pipeline:
  - Stage 0: RAM read, addressed by thread t.
  - Stage 1: masking, registered.
  - Stage 2: compare against `R`, combinational.
- `R` for thread t must arrive 2 cycles after the thread counter shows t. `match` is combinational from `R`.
- Sweep length: exactly `THREAD_COUNT` cycles after the cycle `clear` is sampled high while `clear` stays low.
- `ready` rises in the first RUN cycle.
- `match` and `any_match` are gated low until 2 cycles after `ready` rises, so no pre-sweep RAM contents are ever reported.
- Reset values:
  - `ready`, `match`, `any_match`, `hit_count` = 0.
  - Thread counter = 0.
  - Sweep address = 0.

## Configuration
- `BRANCH_SENTINEL_BANK_HIT_COUNT_EN` defined:
  - Adds a per-thread counter RAM, cleared to 0 by the sweep.
  - Read at stage 0; value carried to stage 2.
  - In RUN, when gated `any_match` = 1, the counter increments, saturating at all-ones, and is written back to the stage-2 thread.
  - `hit_count` shows the pre-increment value.
- Macro undefined: no counter RAM and no counter logic; `hit_count` is tied to 0.

## Structure
- Shared package holds:
  - FSM state typedef (SWEEP, RUN).
  - Constants `SEL_SENTINEL` = 0 and `SEL_MASK` = 1.
  - Configuration-address field widths.
- Existing parts reused: `Thread_Number`, `RAM_SDP`, `Delay_Line`.
- One new sub-module: `sentinel_entry`, holding one entry's sentinel and mask RAMs, the stage-1 mask register and the stage-2 compare. It is instantiated `SENTINEL_COUNT` times by a generate loop.

## Test plan
Bench parameters: `THREAD_COUNT` = 8, `SENTINEL_COUNT` = 4, `WORD_WIDTH` = 36.
- Post-clear zero match:
  - Pulse `clear` -> `ready` goes high exactly 8 cycles later.
  - Once the output gating lifts, `R` = 0 on every thread -> `match` = 4'b1111.
  - `R` = 1 -> `match` = 0.
- Masked match: thread 3, entry 2 written with sentinel 0xABC and mask 0x00F.
  - `R` = 0xAB5 on thread 3 -> `match[2]` = 1.
  - `R` = 0xAB5 on thread 4 -> `match[2]` = 0.
- Mid-sweep clear: assert `clear` 5 cycles into the sweep -> sweep restarts; `ready` rises 8 cycles after the second clear.
- Writes ignored outside RUN:
  - Configuration write during SWEEP -> no effect.
  - Write with entry index 5 (≥ `SENTINEL_COUNT`) in RUN -> no RAM changes.
- Hit count (macro defined), `HIT_COUNT_WIDTH` = 2: thread 1 matches on 5 consecutive passes -> `hit_count` reads 0, 1, 2, 3, 3.
